// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and load-lane extraction for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // Pick the addressed byte/half out of a storage word and extend it to 32 bits.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  addr_lo,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr_lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~is_unsigned}}, b};
            SZ_HALF: r = {{16{h[15] & ~is_unsigned}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the data-memory responder (slave).
interface dmem_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [31:0] readData;
    logic        respValid;
    logic        memStall;
    logic        accessErr;

    modport master (
        output memRead, memWrite, addr, writeData, size, isUnsigned,
        input  readData, respValid, memStall, accessErr
    );

    modport slave (
        input  memRead, memWrite, addr, writeData, size, isUnsigned,
        output readData, respValid, memStall, accessErr
    );
endinterface

// File: rtl/dmem_store_array.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
module dmem_store_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are never reset; read data only updates on a read access so it holds across stores.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (|be_i) begin
                for (int l = 0; l < 4; l++) begin
                    if (be_i[l]) begin
                        mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts a load/store, stalls for WAIT_STATES cycles, then pulses respValid.
// Misaligned or read+write requests skip the wait and answer with accessErr and no storage access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        ld_q, ld_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic        req;
    logic        bad_req;
    logic        access;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata;
    logic        unused_addr_hi;

    assign req            = bus.memRead | bus.memWrite;
    assign unused_addr_hi = ^bus.addr[31:IDX_W+2];

    always_comb begin
        bad_req = (bus.memRead & bus.memWrite)
                | ((bus.size == SZ_HALF) & bus.addr[0])
                | (bus.size[1] & (bus.addr[1:0] != 2'b00));
    end

    // Lane placement of store data; size 2'b11 behaves as a word.
    always_comb begin
        be_calc    = 4'hF;
        wdata_calc = bus.writeData;
        case (bus.size)
            SZ_BYTE: begin
                be_calc    = 4'b0001 << bus.addr[1:0];
                wdata_calc = {4{bus.writeData[7:0]}};
            end
            SZ_HALF: begin
                be_calc    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{bus.writeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        ld_d          = ld_q;
        lo_d          = lo_q;
        size_d        = size_q;
        uns_d         = uns_q;
        access        = 1'b0;
        bus.memStall  = 1'b0;
        bus.respValid = 1'b0;
        bus.accessErr = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    bus.memStall = 1'b1;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        ld_d    = 1'b0;
                        state_d = RESP;
                    end else if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                bus.memStall = 1'b1;
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                bus.respValid = 1'b1;
                bus.accessErr = err_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Request fields are taken at the access edge, which is when storage is touched.
        if (access) begin
            err_d  = 1'b0;
            ld_d   = bus.memRead & ~bus.memWrite;
            lo_d   = bus.addr[1:0];
            size_d = bus.size;
            uns_d  = bus.isUnsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            lo_q    <= 2'd0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end

    // Gating with reset drops a store whose access edge coincides with reset.
    dmem_store_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .en_i    (access & ~reset),
        .be_i    ((bus.memWrite & ~bus.memRead) ? be_calc : 4'h0),
        .idx_i   (bus.addr[IDX_W+1:2]),
        .wdata_i (wdata_calc),
        .rdata_o (rdata)
    );

    assign bus.readData = ld_q ? lane_extend(rdata, lo_q, size_q, uns_q) : 32'h0;

endmodule
